// File: rtl/risc_v_pkg.sv
// risc_v_pkg: shared widths, reset address, NOP encoding and fetch states
package risc_v_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALTED} fetch_state_t;
endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch sequencer driving the imem address and handing words to decode
// CLK/RST: clock, async active-high reset; pc_out/imem_req/imem_rdata: imem side
// redirect_valid/redirect_pc/halt: control; inst_*: decode handshake; busy: REQ or WAIT
module fetch_ctrl #(
  parameter int XLEN = risc_v_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = risc_v_pkg::RESET_PC,
  parameter int MEM_LAT = 1
) (
  input  logic            CLK,
  input  logic            RST,
  output logic [XLEN-1:0] pc_out,
  output logic            imem_req,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            busy
);
  import risc_v_pkg::*;
  fetch_state_t r_state;
  logic [XLEN-1:0] r_pc, r_inst_data, r_inst_pc;
  logic [2:0] r_cnt;
  logic r_inst_valid;
  logic [XLEN-1:0] w_redirect_pc;
  fetch_state_t w_resume;
  assign w_redirect_pc = redirect_pc & ~XLEN'(3);
  assign w_resume = halt ? HALTED : REQ;
  assign pc_out = r_pc;
  assign imem_req = r_state == REQ;
  assign busy = r_state == REQ || r_state == WAIT;
  assign inst_valid = r_inst_valid;
  assign inst_data = r_inst_data;
  assign inst_pc = r_inst_pc;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_state <= IDLE;
      r_pc <= RESET_PC;
      r_cnt <= '0;
      r_inst_valid <= 1'b0;
      r_inst_data <= XLEN'(NOP);
      r_inst_pc <= RESET_PC;
    end else begin
      case (r_state)
        IDLE: r_state <= w_resume;
        REQ: begin
          r_cnt <= 3'(MEM_LAT);
          r_state <= WAIT;
        end
        WAIT:
          if (r_cnt != 3'd1) r_cnt <= r_cnt - 3'd1;
          else if (!redirect_valid) begin
            r_inst_data <= imem_rdata;
            r_inst_pc <= r_pc;
            r_inst_valid <= 1'b1;
            r_pc <= r_pc + XLEN'(4);
            r_state <= HOLD;
          end
        HOLD:
          if (inst_ready) begin
            r_inst_valid <= 1'b0;
            r_state <= w_resume;
          end
        HALTED: if (!halt) r_state <= REQ;
        default: r_state <= IDLE;
      endcase
      // a redirect overrides whatever the state logic above chose
      if (redirect_valid && r_state != IDLE) begin
        r_pc <= w_redirect_pc;
        r_inst_valid <= 1'b0;
        r_state <= w_resume;
      end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and random checks of two fetch_ctrl configurations against a timing model
module tb_fetch_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic halt = 1'b0, redirect_valid = 1'b0, inst_ready = 1'b1;
  logic [31:0] redirect_pc = '0;
  logic [31:0] pc_o[2], rdata[2], data_o[2], ipc_o[2];
  logic req_o[2], valid_o[2], busy_o[2];
  int checks = 0, failures = 0, cyc = 0;
  localparam int ML[2] = '{1, 3};
  localparam logic [31:0] MRST[2] = '{32'h0000_0000, 32'hFFFF_FFFC};
  always #5 CLK = ~CLK;

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .MEM_LAT(1)) u0 (
    .CLK(CLK), .RST(RST), .pc_out(pc_o[0]), .imem_req(req_o[0]), .imem_rdata(rdata[0]),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .inst_valid(valid_o[0]), .inst_ready(inst_ready), .inst_data(data_o[0]),
    .inst_pc(ipc_o[0]), .busy(busy_o[0]));

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC), .MEM_LAT(3)) u1 (
    .CLK(CLK), .RST(RST), .pc_out(pc_o[1]), .imem_req(req_o[1]), .imem_rdata(rdata[1]),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .inst_valid(valid_o[1]), .inst_ready(inst_ready), .inst_data(data_o[1]),
    .inst_pc(ipc_o[1]), .busy(busy_o[1]));

  function automatic logic [31:0] mem(logic [31:0] a);
    return a == 32'h0 ? 32'h0000_0093 : a == 32'h4 ? 32'h0010_0113 : (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // memory returns the word only exactly MEM_LAT cycles after the request, garbage otherwise
  logic [3:0] hq[2] = '{4'h0, 4'h0};
  logic [31:0] ha[2][4];
  always @(posedge CLK)
    for (int k = 0; k < 2; k++) begin
      hq[k] <= {hq[k][2:0], req_o[k]};
      ha[k][0] <= pc_o[k];
      for (int j = 1; j < 4; j++) ha[k][j] <= ha[k][j-1];
    end
  assign rdata[0] = hq[0][0] ? mem(ha[0][0]) : 32'hDEAD_BEEF;
  assign rdata[1] = hq[1][2] ? mem(ha[1][2]) : 32'hDEAD_BEEF;

  // model: fetch request cycle number plus delivered-instruction bookkeeping
  logic [31:0] m_pc[2], m_data[2], m_ipc[2];
  bit m_valid[2], m_halted[2], m_idle[2];
  int m_req[2];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = MRST[k];
      m_ipc[k] = MRST[k];
      m_data[k] = 32'h0000_0013;
      m_valid[k] = 0;
      m_halted[k] = 0;
      m_idle[k] = 1;
      m_req[k] = -1;
    end
    cyc = 0;
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (m_idle[k]) begin
        m_idle[k] = 0;
        m_halted[k] = halt;
        m_req[k] = halt ? -1 : cyc + 1;
      end else if (redirect_valid) begin
        m_pc[k] = {redirect_pc[31:2], 2'b00};
        m_valid[k] = 0;
        m_halted[k] = halt;
        m_req[k] = halt ? -1 : cyc + 1;
      end else if (m_halted[k]) begin
        if (!halt) begin
          m_halted[k] = 0;
          m_req[k] = cyc + 1;
        end
      end else if (m_valid[k]) begin
        if (inst_ready) begin
          m_valid[k] = 0;
          m_halted[k] = halt;
          m_req[k] = halt ? -1 : cyc + 1;
        end
      end else if (m_req[k] >= 0 && cyc == m_req[k] + ML[k]) begin
        m_data[k] = mem(m_pc[k]);
        m_ipc[k] = m_pc[k];
        m_valid[k] = 1;
        m_pc[k] = m_pc[k] + 32'd4;
        m_req[k] = -1;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("pc_out%0d", k), pc_o[k], m_pc[k]);
      chk($sformatf("imem_req%0d", k), req_o[k], 32'(m_req[k] == cyc));
      chk($sformatf("busy%0d", k), busy_o[k],
          32'(m_req[k] >= 0 && cyc >= m_req[k] && cyc <= m_req[k] + ML[k]));
      chk($sformatf("inst_valid%0d", k), valid_o[k], 32'(m_valid[k]));
      chk($sformatf("inst_data%0d", k), data_o[k], m_data[k]);
      chk($sformatf("inst_pc%0d", k), ipc_o[k], m_ipc[k]);
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_step();
    cyc++;
    @(negedge CLK);
    check_all();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    model_reset();
    check_all();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    check_all();
  endtask

  initial begin
    @(negedge CLK);
    do_reset();
    cycle();
    chk("req_c1", req_o[0], 1);
    cycle();
    cycle();
    chk("valid_c3", valid_o[0], 1);
    chk("ipc_c3", ipc_o[0], 32'h0);
    chk("data_c3", data_o[0], 32'h0000_0093);
    inst_ready = 1'b0;
    repeat (5) begin
      cycle();
      chk("stall_valid", valid_o[0], 1);
      chk("stall_ipc", ipc_o[0], 32'h0);
      chk("stall_req", req_o[0], 0);
      chk("stall_pc", pc_o[0], 32'h4);
    end
    chk("wrap_ipc0", ipc_o[1], 32'hFFFF_FFFC);
    chk("wrap_valid0", valid_o[1], 1);
    inst_ready = 1'b1;
    cycle();
    chk("req_c9", req_o[0], 1);
    cycle();
    cycle();
    chk("ipc_c11", ipc_o[0], 32'h4);
    chk("data_c11", data_o[0], 32'h0010_0113);
    cycle();
    cycle();
    chk("wrap_ipc1", ipc_o[1], 32'h0);
    chk("wrap_valid1", valid_o[1], 1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    cycle();
    redirect_valid = 1'b0;
    chk("redir_pc", pc_o[0], 32'h0000_0100);
    chk("redir_drop", valid_o[0], 0);
    cycle();
    cycle();
    chk("redir_ipc", ipc_o[0], 32'h0000_0100);
    chk("redir_valid", valid_o[0], 1);
    cycle();
    cycle();
    halt = 1'b1;
    cycle();
    chk("halt_deliver", valid_o[0], 1);
    chk("halt_ipc", ipc_o[0], 32'h0000_0104);
    repeat (4) begin
      cycle();
      chk("halted_valid", valid_o[0], 0);
      chk("halted_req", req_o[0], 0);
    end
    halt = 1'b0;
    cycle();
    chk("resume_req", req_o[0], 1);
    do_reset();
    repeat (3) cycle();
    chk("busy_pre_rst", busy_o[1], 1);
    do_reset();
    chk("rst_pc1", pc_o[1], 32'hFFFF_FFFC);
    chk("rst_data1", data_o[1], 32'h0000_0013);
    chk("rst_valid1", valid_o[1], 0);
    repeat (8) cycle();
    repeat (400) begin
      halt = $urandom_range(0, 9) == 0;
      redirect_valid = $urandom_range(0, 11) == 0;
      redirect_pc = $urandom;
      inst_ready = $urandom_range(0, 9) < 7;
      cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
